// File: rtl/i2c_target_regs_if.sv
// Host-side port of the I2C register target: register access plus
// strobes/status reporting I2C-side activity.
interface i2c_target_regs_if #(parameter int PW = 4);
  logic          h_we;
  logic [PW-1:0] h_addr;
  logic [7:0]    h_wdata;
  logic [7:0]    h_rdata;
  logic          wr_strobe;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_strobe;
  logic [PW-1:0] rd_addr;
  logic          busy;

  modport master (
    output h_we, h_addr, h_wdata,
    input  h_rdata, wr_strobe, wr_addr, wr_data, rd_strobe, rd_addr, busy
  );
  modport slave (
    input  h_we, h_addr, h_wdata,
    output h_rdata, wr_strobe, wr_addr, wr_data, rd_strobe, rd_addr, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a DEPTH x 8 register file, auto-incrementing pointer,
// repeated-START support and a shared host port.
module i2c_target_regs #(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  inout  wire  sda,
  i2c_target_regs_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q, scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Sync flops reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

  state_t        state, state_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          rw, rw_n, sda_oe, sda_oe_n, busy_r, busy_n, wr_pend, wr_pend_n;
  logic          i2c_we, rd_ld;
  logic [7:0]    regs [DEPTH];
  logic [7:0]    cur_reg;

  assign cur_reg = regs[ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy_r  <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      state   <= state_n;
      bitcnt  <= bitcnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      sda_oe  <= sda_oe_n;
      busy_r  <= busy_n;
      wr_pend <= wr_pend_n;
    end
  end

  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    sda_oe_n  = sda_oe;
    busy_n    = busy_r;
    wr_pend_n = 1'b0;
    i2c_we    = 1'b0;
    rd_ld     = 1'b0;
    if (start_det) begin
      state_n  = ADDR;
      bitcnt_n = '0;
      sda_oe_n = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      unique case (state)
        ADDR, PTR, WDATA: begin
          // Byte lands in regs the cycle after its 8th sampled bit.
          if (wr_pend) begin
            i2c_we = 1'b1;
            ptr_n  = ptr + PW'(1);
          end
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_s};
            bitcnt_n = bitcnt + 4'd1;
            if (state == WDATA && bitcnt == 4'd7) wr_pend_n = 1'b1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            bitcnt_n = '0;
            sda_oe_n = 1'b1;
            if (state == ADDR) begin
              if (shreg[7:1] == ADDRESS) begin
                rw_n    = shreg[0];
                busy_n  = 1'b1;
                state_n = ADDR_ACK;
              end else begin
                sda_oe_n = 1'b0;
                busy_n   = 1'b0;
                state_n  = IGNORE;
              end
            end else if (state == PTR) begin
              ptr_n   = shreg[PW-1:0];
              state_n = PTR_ACK;
            end else begin
              state_n = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK: begin
          if (state == RDATA_ACK && scl_rise) shreg_n[0] = sda_s;
          if (scl_fall) begin
            bitcnt_n = '0;
            sda_oe_n = 1'b0;
            if ((state == ADDR_ACK && rw) || (state == RDATA_ACK && !shreg[0])) begin
              shreg_n  = cur_reg;
              sda_oe_n = ~cur_reg[7];
              ptr_n    = ptr + PW'(1);
              rd_ld    = 1'b1;
              state_n  = RDATA;
            end else if (state == RDATA_ACK) begin
              state_n = IGNORE;
            end else if (state == ADDR_ACK) begin
              state_n = PTR;
            end else begin
              state_n = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = RDATA_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // I2C write is applied after the host write so it wins on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (bus.h_we) regs[bus.h_addr] <= bus.h_wdata;
      if (i2c_we)   regs[ptr]        <= shreg;
    end
  end

  logic          wr_stb_r, rd_stb_r;
  logic [PW-1:0] wr_addr_r, rd_addr_r;
  logic [7:0]    wr_data_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_stb_r  <= 1'b0;
      rd_stb_r  <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      rd_addr_r <= '0;
    end else begin
      wr_stb_r <= i2c_we;
      rd_stb_r <= rd_ld;
      if (i2c_we) begin
        wr_addr_r <= ptr;
        wr_data_r <= shreg;
      end
      if (rd_ld) rd_addr_r <= ptr;
    end
  end

  assign sda           = sda_oe ? 1'b0 : 1'bz;
  assign bus.h_rdata   = regs[bus.h_addr];
  assign bus.wr_strobe = wr_stb_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.rd_strobe = rd_stb_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.busy      = busy_r;

endmodule
